// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Bit i set means digit index i lights its decimal point.
    localparam logic [5:0] DP_MASK = 6'b001010;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/disp_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder; A..F show a dash.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// Six-digit common-anode scanner: snapshots the BCD buffer once per frame and
// drives one digit per slot with a blanked lead-in; all outputs are registered.
module disp_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
)(
    input  logic        clk_50Mhz,
    input  logic        rst,
    input  logic [23:0] dispbuf,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [5:0]  an,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]    idx;
    logic [23:0]   frame_buf;
    scan_state_t   state;
    scan_state_t   state_nxt;
    logic          slot_end;
    logic [3:0]    nib;
    logic          dp_on;
    logic [6:0]    seg_dec;
    logic [7:0]    seg_nxt;
    logic [5:0]    an_nxt;

    assign slot_end = (cnt == CW'(SCAN_DIV - 1));
    assign cnt_nxt  = slot_end ? '0 : cnt + CW'(1);

    seg7_decode u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    // Nibble and dp selection for the digit currently being scanned.
    always_comb begin
        nib   = 4'd0;
        dp_on = 1'b0;
        case (idx)
            3'd0: begin nib = frame_buf[23:20]; dp_on = DP_MASK[0]; end
            3'd1: begin nib = frame_buf[19:16]; dp_on = DP_MASK[1]; end
            3'd2: begin nib = frame_buf[15:12]; dp_on = DP_MASK[2]; end
            3'd3: begin nib = frame_buf[11:8];  dp_on = DP_MASK[3]; end
            3'd4: begin nib = frame_buf[7:4];   dp_on = DP_MASK[4]; end
            3'd5: begin nib = frame_buf[3:0];   dp_on = DP_MASK[5]; end
            default: begin nib = 4'd0; dp_on = 1'b0; end
        endcase
    end

    // State tracks the current counter value; outputs are computed from it
    // and registered, so the pins lag the counter by one cycle.
    always_comb begin
        state_nxt = state;
        an_nxt    = 6'b111111;
        seg_nxt   = SEG_BLANK;
        if (slot_end) begin
            state_nxt = ST_BLANK;
        end else if (cnt_nxt == CW'(BLANK_CYC)) begin
            state_nxt = ST_SHOW;
        end
        if (state == ST_SHOW) begin
            an_nxt = ~(6'b100000 >> idx);
            if (idx == 3'd0 && blank_lz && nib == 4'd0) begin
                seg_nxt = SEG_BLANK;
            end else begin
                seg_nxt = {~dp_on, seg_dec};
            end
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 3'd0;
            frame_buf  <= 24'h0;
            state      <= ST_BLANK;
            an         <= 6'b111111;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
            if (slot_end) begin
                idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            end
            // One snapshot per frame keeps a frame free of tearing.
            if (cnt == '0 && idx == 3'd0) begin
                frame_buf <= dispbuf;
            end
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= slot_end && (idx == 3'(NUM_DIGITS - 1));
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with SCAN_DIV=8, BLANK_CYC=2.
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] dispbuf;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [5:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int onehot_viol = 0;
    int gap_viol = 0;
    int off_run = 0;
    logic [5:0] last_low = 6'b111111;

    always #5 clk = ~clk;

    disp_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk_50Mhz  (clk),
        .rst        (rst),
        .dispbuf    (dispbuf),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Anode safety monitor: never two digits on, and >=2 dark cycles between digits.
    always @(negedge clk) begin
        if ($countones(~an) > 1) onehot_viol++;
        if (an == 6'b111111) begin
            off_run++;
        end else begin
            if (last_low != 6'b111111 && an != last_low && off_run < 2) gap_viol++;
            last_low = an;
            off_run  = 0;
        end
    end

    task automatic run_slot(input int di, input logic [7:0] seg_exp);
        logic [5:0] an_exp;
        logic       fd_exp;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            an_exp = (c < 2) ? 6'b111111 : ~(6'b100000 >> di);
            fd_exp = (di == 5 && c == 7);
            chk($sformatf("an d%0d c%0d", di, c), {26'd0, an}, {26'd0, an_exp});
            if (c >= 2) chk($sformatf("seg d%0d c%0d", di, c), {24'd0, seg}, {24'd0, seg_exp});
            else        chk($sformatf("seg_blank d%0d c%0d", di, c), {24'd0, seg}, 32'hFF);
            chk($sformatf("frame_done d%0d c%0d", di, c), {31'd0, frame_done}, {31'd0, fd_exp});
        end
    endtask

    task automatic run_frame(input logic [47:0] e);
        for (int i = 0; i < 6; i++) run_slot(i, e[47 - 8*i -: 8]);
    endtask

    initial begin
        rst      = 1'b1;
        dispbuf  = 24'h123456;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst an", {26'd0, an}, 32'h3F);
        chk("rst seg", {24'd0, seg}, 32'hFF);
        chk("rst frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Frame 1: 1 2. 3 4. 5 6
        run_frame({8'hF9, 8'h24, 8'hB0, 8'h19, 8'h92, 8'h82});

        // Frame 2: buffer changes during index 2; this frame keeps 123456
        run_slot(0, 8'hF9);
        run_slot(1, 8'h24);
        dispbuf = 24'h999999;
        run_slot(2, 8'hB0);
        run_slot(3, 8'h19);
        run_slot(4, 8'h92);
        run_slot(5, 8'h82);

        // Frame 3: all nines; queue 012345 for the next frame
        run_slot(0, 8'h90);
        dispbuf  = 24'h012345;
        blank_lz = 1'b1;
        run_slot(1, 8'h10);
        run_slot(2, 8'h90);
        run_slot(3, 8'h10);
        run_slot(4, 8'h90);
        run_slot(5, 8'h90);

        // Frame 4: leading zero suppressed, anode still scanned
        run_frame({8'hFF, 8'h79, 8'hA4, 8'h30, 8'h99, 8'h92});
        blank_lz = 1'b0;

        // Frame 5: same data, zero shown; queue AF0000
        run_slot(0, 8'hC0);
        dispbuf = 24'hAF0000;
        run_slot(1, 8'h79);
        run_slot(2, 8'hA4);
        run_slot(3, 8'h30);
        run_slot(4, 8'h99);
        run_slot(5, 8'h92);

        // Frame 6: dashes for A and F, dp on index 1
        run_frame({8'hBF, 8'h3F, 8'hC0, 8'h40, 8'hC0, 8'hC0});

        // Frame 7: reset while index 3 is showing
        run_slot(0, 8'hBF);
        run_slot(1, 8'h3F);
        run_slot(2, 8'hC0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst an", {26'd0, an}, 32'h3B);
        rst     = 1'b1;
        dispbuf = 24'h654321;
        @(posedge clk); #1;
        chk("midrst an", {26'd0, an}, 32'h3F);
        chk("midrst seg", {24'd0, seg}, 32'hFF);
        chk("midrst frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Fresh frames after reset: 6 5. 4 3. 2 1
        run_frame({8'h82, 8'h12, 8'h99, 8'h30, 8'hA4, 8'hF9});
        run_frame({8'h82, 8'h12, 8'h99, 8'h30, 8'hA4, 8'hF9});
        run_frame({8'h82, 8'h12, 8'h99, 8'h30, 8'hA4, 8'hF9});

        @(negedge clk);
        chk("onehot_viol", onehot_viol, 32'd0);
        chk("gap_viol", gap_viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
Name: disp_scan

Overview:
- Consumer end of the stopwatch `dispbuf` interface. It drives a 6-digit, common-anode, multiplexed 7-segment display.
- Each frame it latches a snapshot of the packed BCD buffer (minute1, minute0, sec1, sec0, msec2, msec1) and scans one digit at a time.
- A blanking gap between digits suppresses ghosting.
- Sits between the counter block and the board pins, in the `clk_50Mhz` domain.

Parameters:
- SCAN_DIV, 50000: cycles per digit slot; 1 kHz slot rate at 50 MHz. Legal range 2..2^20.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off. Legal range 1..SCAN_DIV-1.

Ports:
- clk_50Mhz  input  1  system clock
- rst  input  1  synchronous, active-high reset
- dispbuf  input  24  packed BCD; [23:20]=minute1 ... [3:0]=msec1
- blank_lz  input  1  1 = suppress a leading zero in minute1
- seg  output  8  active-low segments; [6:0]=g,f,e,d,c,b,a; [7]=dp
- an  output  6  active-low digit enables; an[5]=minute1 ... an[0]=msec1
- frame_done  output  1  one-cycle pulse at the end of each full 6-digit frame

Behaviour:
- Single clock `clk_50Mhz`. `rst` is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - an=6'b111111, seg=8'hFF, frame_done=0.
  - Slot counter=0, digit index=0, frame_buf=24'h0, state=BLANK.
- Slot counter: counts 0..SCAN_DIV-1 and wraps to 0.
- Digit index (0..5): advances on wrap. Index 0 is minute1 (frame_buf[23:20]); index 5 is msec1. After 5 it wraps to 0.
- Snapshot: at slot counter 0 of index 0, frame_buf <= dispbuf.
  - The first such cycle is the first cycle after rst deasserts.
  - Changes to dispbuf mid-frame are not displayed until the next frame; no tearing within a frame.
- State machine (2 states):
  - BLANK: slot counter < BLANK_CYC. Next-cycle outputs are an=all 1s, seg=8'hFF.
  - SHOW: slot counter >= BLANK_CYC. The digit is driven as described under Outputs.
  - Transitions: BLANK->SHOW when slot counter reaches BLANK_CYC; SHOW->BLANK on slot wrap.
- Outputs (SHOW state):
  - an = active-low one-hot, with the low bit at position 5-index.
  - seg = decode of the current frame_buf nibble.
- Output latency: outputs are registered, one cycle after the counter value that selects them. In slot k, an for digit k is low for exactly SCAN_DIV-BLANK_CYC consecutive cycles.
- Decode:
  - 0..9 use standard segment codes, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - Nibbles A..F display a dash (7'b0111111).
- Decimal point: seg[7]=0 on index 1 (minute0) and index 3 (sec0); 1 otherwise.
- Leading-zero suppression: if blank_lz=1 and the index 0 nibble is 0, seg=8'hFF for that slot, but an still follows the scan. blank_lz is sampled live, not snapshotted.
- frame_done: high for the single cycle whose registered outputs correspond to slot counter SCAN_DIV-1 of index 5, i.e. aligned with the last SHOW cycle of msec1.
- Reset mid-frame: all state returns to reset values on the next edge. No partial digit is driven in the reset cycle; outputs are all 1s.
- No two anodes are ever low in the same cycle. Every digit-to-digit transition passes through at least BLANK_CYC all-off cycles.

Decomposition:
- Shared package disp_pkg:
  - NUM_DIGITS=6.
  - SEG_BLANK=8'hFF.
  - SEG_DASH, and segment code constants for 0..9.
  - DP_MASK=6'b001010 (a 1 marks a digit index whose dp is lit).
- Sub-module seg7_decode: purely combinational, 4-bit nibble -> 7-bit active-low segments. It is reused by any future display path.
- disp_scan holds the counters, state machine, snapshot register, dp/blanking muxes and output registers.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
- Reset, then dispbuf=24'h123456, blank_lz=0:
  - Each slot shows 2 cycles an=111111, then 6 cycles with a single zero walking an[5]->an[0].
  - seg digits 1,2(dp),3,4(dp),5,6, i.e. seg=8'b11111001 for the first digit.
  - frame_done pulses once every 48 cycles.
- Change dispbuf from 24'h123456 to 24'h999999 during index 2 of a frame:
  - Remaining digits of that frame still show 3,4,5,6.
  - The next frame shows all 9s.
- dispbuf=24'h012345 with blank_lz=1:
  - Index 0 slot has an[5]=0 during SHOW with seg=8'hFF.
  - With blank_lz=0 the same slot shows 0 (seg=8'b11000000).
- dispbuf=24'hAF0000: indices 0 and 1 show the dash; index 1 also has the dp low (seg=8'b00111111).
- Assert rst for 1 cycle while index 3 is in SHOW:
  - Next cycle an=111111, seg=8'hFF.
  - The scan restarts at index 0 with a fresh snapshot.
  - frame_done does not pulse until 48 cycles later.
- Continuous checker over 10 frames:
  - Popcount of ~an is never above 1.
  - Every transition between two different low anodes has at least 2 all-off cycles in between.
